pulse_pacer: RTL
================

// Module: pulse_pacer
// PURPOSE
//  Transmit-side event pacer. It sits directly upstream of the XOR/toggle pulse
//  synchronizer, in the TX clock domain.
//  Event requests are counted and then re-issued as single-cycle pulses, spaced at
//  least MIN_GAP cycles apart. Without this spacing the toggle synchronizer would
//  merge or lose pulses that arrive closer together than the RX side can resolve.
//  Overflow of the pending-event counter is reported with a sticky flag.
// PARAMETERS
//  CNT_W    4   width of the pending-event counter; capacity MAX = 2**CNT_W-1
//  MIN_GAP  4   minimum cycles between rising edges of pulse_out; legal range >=2
// PORTS
//  clk        in   1      single clock (TX domain); all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      1: pulses may be issued; 0: hold issuing, keep counting
//  req_valid  in   1      event request, one event per cycle while high
//  req_ready  out  1      1: a request is accepted this cycle
//  pulse_out  out  1      single-cycle pulse to the synchronizer IN port; registered
//  pending    out  CNT_W  events accepted but not yet issued
//  busy       out  1      state!=IDLE or pending!=0
//  drop_err   out  1      sticky: a request was presented while req_ready=0
// BEHAVIOUR
//  Reset: sampled at posedge while rst=1.
//   - State=IDLE, pending=0, gap counter=0, pulse_out=0, drop_err=0.
//   - Reset mid-operation discards all pending events and truncates any GAP.
//   - pulse_out is 0 in the cycle after the reset edge.
//  Accept:
//   - accept = req_valid & req_ready.
//   - req_ready = (pending != MAX); derived from registered state only, no path
//     from req_valid.
//  Fire:
//   - fire = (state==IDLE) & en & (pending != 0); registered pending only.
//  Counter update at each edge: pending <= pending + accept - fire.
//   - Accept and fire in the same cycle leave pending unchanged.
//   - pending == MAX with fire: req_ready stays 0 that cycle (no look-ahead).
//   - No wrap-around in either direction: increment at MAX is impossible since
//     req_ready=0; decrement below 0 is impossible since fire needs pending!=0.
//  Overflow: req_valid & ~req_ready at an edge sets drop_err=1.
//   - The event is lost.
//   - drop_err is cleared only by rst.
//  FSM (pulse_out = state==FIRE, registered):
//   - IDLE -> FIRE when fire; otherwise stay in IDLE.
//   - FIRE -> GAP when MIN_GAP>2, loading gap counter with MIN_GAP-3.
//   - FIRE -> IDLE when MIN_GAP==2.
//   - GAP: counts down; -> IDLE when counter==0.
//  Timing:
//   - FIRE lasts 1 cycle, GAP lasts MIN_GAP-2 cycles, IDLE lasts >=1 cycle.
//   - Back-to-back pending events give rising edges exactly MIN_GAP cycles apart.
//   - Latency: req_valid accepted in cycle n (pending was 0, en=1) gives
//     pulse_out=1 in cycle n+2.
//  en:
//   - en=0 blocks only the IDLE->FIRE transition.
//   - FIRE/GAP in progress complete normally.
//   - Accepts continue while en=0.
//  busy: drops in the first IDLE cycle with pending==0.
//  Width: pending is unsigned CNT_W bits; gap counter is $clog2(MIN_GAP) bits.
// TESTING
//  1 single req_valid in cycle 0, en=1 -> pulse_out=1 only in cycle 2, pending 1 in
//    cycle 1, 0 in cycle 2; busy low from cycle 5 (MIN_GAP=4)
//  2 req_valid cycles 0-2 -> pulse_out high cycles 2,6,10; pending max 2;
//    drop_err=0
//  3 en=0, 16 requests (CNT_W=4) -> pending=15, req_ready=0 after 15th; 16th sets
//    drop_err=1; en=1 -> 15 pulses, 4 cycles apart
//  4 pending=3 in IDLE, req_valid=1 on fire cycle -> pending stays 3, pulse_out=1
//    next cycle
//  5 rst=1 for one cycle during GAP with pending=5 -> next cycle pulse_out=0,
//    pending=0, busy=0, drop_err=0
//  6 MIN_GAP=2, 4 queued events -> pulses every 2nd cycle, never two consecutive
//    pulse_out=1 cycles

Source files
------------

// File: rtl/pulse_pacer.sv
// pulse_pacer: counts incoming event requests and re-issues them as single-cycle
// pulses spaced at least MIN_GAP cycles apart, so a downstream toggle
// synchronizer never sees two events closer than it can resolve. A sticky
// drop_err flag records any request that arrived while the counter was full.
module pulse_pacer #(
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             drop_err
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] MAX_PEND = '1;
  // GAP holds for MIN_GAP-2 cycles; the counter counts down to zero inclusive.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 2) ? (MIN_GAP - 3) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               drop_q, drop_d;
  logic               accept;
  logic               fire;

  // Handshake and fire decision come from registered state only, so there is
  // no combinational path from req_valid to req_ready.
  assign req_ready = (pending_q != MAX_PEND);
  assign accept    = req_valid & req_ready;
  assign fire      = (state_q == IDLE) & en & (pending_q != '0);

  assign pulse_out = (state_q == FIRE);
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE) | (pending_q != '0);
  assign drop_err  = drop_q;

  // Next-state logic: pending counter, sticky overflow flag and pacing FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    gap_d     = gap_q;
    drop_d    = drop_q;

    if (accept && !fire) begin
      pending_d = pending_q + 1'b1;
    end else if (fire && !accept) begin
      pending_d = pending_q - 1'b1;
    end

    if (req_valid && !req_ready) begin
      drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        if (MIN_GAP > 2) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gap_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      drop_q    <= drop_d;
    end
  end

endmodule
